// File: rtl/hp_manager_if.sv
// Bundle of the HP manager's game-side signals: frame sync and event pulses in,
// HP bar vectors and round status flags out.
interface hp_manager_if;
    logic       VGA_VS;
    logic       game_start;
    logic       p1_hit;
    logic       p2_hit;
    logic       p1_heal;
    logic       p2_heal;
    logic [4:0] player1_HP;
    logic [4:0] player2_HP;
    logic       p1_dead;
    logic       p2_dead;
    logic       playing;
    logic       game_over;
    logic [1:0] winner;

    modport master (
        output VGA_VS, game_start, p1_hit, p2_hit, p1_heal, p2_heal,
        input  player1_HP, player2_HP, p1_dead, p2_dead, playing, game_over, winner
    );

    modport slave (
        input  VGA_VS, game_start, p1_hit, p2_hit, p1_heal, p2_heal,
        output player1_HP, player2_HP, p1_dead, p2_dead, playing, game_over, winner
    );
endinterface

// File: rtl/hp_manager.sv
// Hit-point manager: owns both players' HP, invulnerability and blink timing
// (frame-paced from VGA vertical sync), and the IDLE/PLAY/OVER round sequence.
module hp_manager #(
    parameter int MAX_HP        = 5,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_HALF    = 4,
    parameter int OVER_FRAMES   = 180
) (
    input logic         Clk,
    input logic         Reset_n,
    hp_manager_if.slave bus
);
    localparam int IW = $clog2(INVULN_FRAMES + 1);
    localparam int BW = $clog2(2 * BLINK_HALF);
    localparam int OW = $clog2(OVER_FRAMES + 1);

    localparam logic [2:0]    HP_FULL    = 3'(MAX_HP);
    localparam logic [IW-1:0] INV_LOAD   = IW'(INVULN_FRAMES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * BLINK_HALF - 1);
    localparam logic [BW-1:0] BLINK_MID  = BW'(BLINK_HALF);
    localparam logic [OW-1:0] OVER_LOAD  = OW'(OVER_FRAMES);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} top_t;
    typedef enum logic [1:0] {ALIVE, INVULN, DEAD} pstate_t;

    typedef struct packed {
        pstate_t       st;
        logic [2:0]    cnt;
        logic [IW-1:0] inv;
        logic [BW-1:0] blink;
    } player_t;

    top_t          top_q, top_n;
    player_t       p1_q, p1_n, p2_q, p2_n;
    logic [OW-1:0] over_q, over_n;
    logic [1:0]    winner_q, winner_n;
    logic          vs_q;
    logic          frame_tick;

    logic [4:0]    hp1_q, hp1_n, hp2_q, hp2_n;
    logic          dead1_q, dead1_n, dead2_q, dead2_n;
    logic          playing_q, playing_n, game_over_q, game_over_n;

    function automatic player_t fresh_player();
        player_t p;
        p.st    = ALIVE;
        p.cnt   = HP_FULL;
        p.inv   = '0;
        p.blink = '0;
        return p;
    endfunction

    // One cycle of a player's ALIVE/INVULN/DEAD behaviour; hit beats heal.
    function automatic player_t step_player(player_t p, logic hit, logic heal, logic tick);
        player_t n;
        n = p;
        case (p.st)
            ALIVE: begin
                if (hit) begin
                    n.cnt = p.cnt - 3'd1;
                    if (p.cnt == 3'd1) begin
                        n.st = DEAD;
                    end else begin
                        n.st    = INVULN;
                        n.inv   = INV_LOAD;
                        n.blink = '0;
                    end
                end else if (heal && p.cnt < HP_FULL) begin
                    n.cnt = p.cnt + 3'd1;
                end
            end
            INVULN: begin
                if (!hit && heal && p.cnt < HP_FULL) begin
                    n.cnt = p.cnt + 3'd1;
                end
                if (tick) begin
                    n.inv   = p.inv - IW'(1);
                    n.blink = (p.blink == BLINK_LAST) ? '0 : p.blink + BW'(1);
                    if (p.inv == IW'(1)) begin
                        n.st = ALIVE;
                    end
                end
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [4:0] therm(logic [2:0] n);
        return ~(5'b11111 >> n);
    endfunction

    // During the dark half of a blink period the last bar is dropped.
    function automatic logic [4:0] show(player_t p);
        if (p.st == INVULN && p.blink >= BLINK_MID) begin
            return therm(p.cnt - 3'd1);
        end
        return therm(p.cnt);
    endfunction

    assign frame_tick = vs_q & ~bus.VGA_VS;

    // Round sequencing and per-player updates; once anyone is dead the other
    // player is frozen so the winner and displayed bars stay consistent.
    always_comb begin
        top_n    = top_q;
        p1_n     = p1_q;
        p2_n     = p2_q;
        over_n   = over_q;
        winner_n = winner_q;
        case (top_q)
            IDLE: begin
                if (bus.game_start) begin
                    top_n    = PLAY;
                    p1_n     = fresh_player();
                    p2_n     = fresh_player();
                    winner_n = 2'b00;
                end
            end
            PLAY: begin
                if (p1_q.st == DEAD || p2_q.st == DEAD) begin
                    top_n    = OVER;
                    over_n   = OVER_LOAD;
                    winner_n = {p1_q.st == DEAD, p2_q.st == DEAD};
                end else begin
                    p1_n = step_player(p1_q, bus.p1_hit, bus.p1_heal, frame_tick);
                    p2_n = step_player(p2_q, bus.p2_hit, bus.p2_heal, frame_tick);
                end
            end
            OVER: begin
                if (bus.game_start) begin
                    top_n    = PLAY;
                    p1_n     = fresh_player();
                    p2_n     = fresh_player();
                    winner_n = 2'b00;
                end else if (frame_tick) begin
                    over_n = over_q - OW'(1);
                    if (over_q == OW'(1)) begin
                        top_n    = IDLE;
                        winner_n = 2'b00;
                        p1_n     = '0;
                        p2_n     = '0;
                    end
                end
            end
            default: top_n = IDLE;
        endcase
    end

    // Output values for the coming state so the registered outputs change on the same edge as the state.
    always_comb begin
        hp1_n       = hp1_q;
        hp2_n       = hp2_q;
        dead1_n     = dead1_q;
        dead2_n     = dead2_q;
        playing_n   = 1'b0;
        game_over_n = 1'b0;
        case (top_n)
            PLAY: begin
                hp1_n     = show(p1_n);
                hp2_n     = show(p2_n);
                dead1_n   = (p1_n.st == DEAD);
                dead2_n   = (p2_n.st == DEAD);
                playing_n = 1'b1;
            end
            OVER: game_over_n = 1'b1;
            default: begin
                hp1_n   = '0;
                hp2_n   = '0;
                dead1_n = 1'b0;
                dead2_n = 1'b0;
            end
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            top_q       <= IDLE;
            p1_q        <= '0;
            p2_q        <= '0;
            over_q      <= '0;
            winner_q    <= 2'b00;
            vs_q        <= 1'b0;
            hp1_q       <= '0;
            hp2_q       <= '0;
            dead1_q     <= 1'b0;
            dead2_q     <= 1'b0;
            playing_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            top_q       <= top_n;
            p1_q        <= p1_n;
            p2_q        <= p2_n;
            over_q      <= over_n;
            winner_q    <= winner_n;
            vs_q        <= bus.VGA_VS;
            hp1_q       <= hp1_n;
            hp2_q       <= hp2_n;
            dead1_q     <= dead1_n;
            dead2_q     <= dead2_n;
            playing_q   <= playing_n;
            game_over_q <= game_over_n;
        end
    end

    assign bus.player1_HP = hp1_q;
    assign bus.player2_HP = hp2_q;
    assign bus.p1_dead    = dead1_q;
    assign bus.p2_dead    = dead2_q;
    assign bus.playing    = playing_q;
    assign bus.game_over  = game_over_q;
    assign bus.winner     = winner_q;
endmodule

// File: tb/tb_hp_manager.sv
// Testbench for hp_manager: directed round scenarios plus random play, with a
// frame-level reference model feeding an expected-output queue.
`timescale 1ns/1ps
module tb_hp_manager;
    localparam int MAX_HP    = 5;
    localparam int INV       = 60;
    localparam int BH        = 4;
    localparam int OVF       = 180;
    localparam int FRAME_LEN = 4;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_OVER = 2;

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;

    hp_manager_if bus();

    hp_manager #(
        .MAX_HP(MAX_HP), .INVULN_FRAMES(INV), .BLINK_HALF(BH), .OVER_FRAMES(OVF)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_exp;
    logic [15:0] act_vec;

    assign act_vec = {bus.player1_HP, bus.player2_HP, bus.p1_dead, bus.p2_dead,
                      bus.playing, bus.game_over, bus.winner};

    // Reference model state, kept in game terms: HP, frames of immunity left, frames left in OVER.
    int         m_top;
    int         m_hp[2];
    int         m_inv[2];
    bit         m_dead[2];
    int         m_over;
    bit [1:0]   m_win;
    bit         m_vs_prev;
    logic [4:0] e_hp[2];
    bit         e_dead[2];
    bit         e_play;
    bit         e_over;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b (hp1 hp2 d1 d2 play over win)", name, act, exp);
        end
    endtask

    function automatic logic [4:0] bars(int n);
        logic [4:0] r;
        r = '0;
        for (int b = 0; b < 5; b++) begin
            if (b < n) r[4-b] = 1'b1;
        end
        return r;
    endfunction

    function automatic bit blinkDark(int inv_left);
        return (inv_left > 0) && (((INV - inv_left) % (2 * BH)) >= BH);
    endfunction

    task automatic modelReset();
        m_top = M_IDLE;
        m_over = 0;
        m_win = 2'b00;
        m_vs_prev = 1'b0;
        e_play = 1'b0;
        e_over = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = 0; m_inv[i] = 0; m_dead[i] = 1'b0;
            e_hp[i] = '0; e_dead[i] = 1'b0;
        end
    endtask

    task automatic modelStart();
        m_top = M_PLAY;
        m_win = 2'b00;
        for (int i = 0; i < 2; i++) begin
            m_hp[i] = MAX_HP; m_inv[i] = 0; m_dead[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input bit vs, input bit gs, input bit h0, input bit h1,
                             input bit he0, input bit he1);
        bit tick;
        bit hit[2];
        bit heal[2];
        bit was_inv;
        tick = m_vs_prev && !vs;
        m_vs_prev = vs;
        hit[0] = h0; hit[1] = h1; heal[0] = he0; heal[1] = he1;
        if (m_top == M_IDLE) begin
            if (gs) modelStart();
        end else if (m_top == M_PLAY) begin
            if (m_dead[0] || m_dead[1]) begin
                m_top = M_OVER;
                m_over = OVF;
                m_win = {m_dead[0], m_dead[1]};
            end else begin
                for (int i = 0; i < 2; i++) begin
                    was_inv = (m_inv[i] > 0);
                    if (hit[i]) begin
                        if (!was_inv) begin
                            m_hp[i] = m_hp[i] - 1;
                            if (m_hp[i] == 0) m_dead[i] = 1'b1;
                            else m_inv[i] = INV;
                        end
                    end else if (heal[i] && m_hp[i] < MAX_HP) begin
                        m_hp[i] = m_hp[i] + 1;
                    end
                    if (was_inv && tick) m_inv[i] = m_inv[i] - 1;
                end
            end
        end else begin
            if (gs) begin
                modelStart();
            end else if (tick) begin
                m_over = m_over - 1;
                if (m_over == 0) begin
                    m_top = M_IDLE;
                    m_win = 2'b00;
                end
            end
        end
        if (m_top == M_PLAY) begin
            for (int i = 0; i < 2; i++) begin
                e_hp[i] = bars(m_hp[i] - (blinkDark(m_inv[i]) ? 1 : 0));
                e_dead[i] = m_dead[i];
            end
            e_play = 1'b1;
            e_over = 1'b0;
        end else if (m_top == M_OVER) begin
            e_play = 1'b0;
            e_over = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                e_hp[i] = '0; e_dead[i] = 1'b0;
            end
            e_play = 1'b0;
            e_over = 1'b0;
        end
        exp_q.push_back({e_hp[0], e_hp[1], e_dead[0], e_dead[1], e_play, e_over, m_win});
    endtask

    // Drives one clock cycle of inputs, with VGA_VS low for one cycle per frame.
    task automatic applyStimulus(input bit gs, input bit h1, input bit h2, input bit he1, input bit he2);
        bus.VGA_VS     = ((cyc % FRAME_LEN) != 0);
        bus.game_start = gs;
        bus.p1_hit     = h1;
        bus.p2_hit     = h2;
        bus.p1_heal    = he1;
        bus.p2_heal    = he2;
        @(posedge Clk);
        modelStep(bus.VGA_VS, gs, h1, h2, he1, he2);
        cyc++;
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleFrames(input int n);
        idleCycles(n * FRAME_LEN);
    endtask

    task automatic doReset(input string name);
        @(negedge Clk);
        #1;
        Reset_n = 1'b0;
        bus.game_start = 1'b0;
        bus.p1_hit = 1'b0; bus.p2_hit = 1'b0;
        bus.p1_heal = 1'b0; bus.p2_heal = 1'b0;
        bus.VGA_VS = 1'b1;
        #1;
        modelReset();
        exp_q.delete();
        checkOutput(name, act_vec, 16'h0000);
        @(negedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    // Monitor: compares every registered output set against the model's prediction.
    always @(negedge Clk) begin
        if (Reset_n && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            checkOutput($sformatf("cycle %0d outputs", cyc), act_vec, mon_exp);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        bus.VGA_VS = 1'b1;
        bus.game_start = 1'b0;
        bus.p1_hit = 1'b0; bus.p2_hit = 1'b0;
        bus.p1_heal = 1'b0; bus.p2_heal = 1'b0;
        modelReset();
        doReset("reset zeros");
        idleCycles(3);

        // Round start and first hit with blink, ignored hit, recovery.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("start full bars", act_vec, {5'b11111, 5'b11111, 6'b001000});
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("p1 first hit", 16'(bus.player1_HP), 16'(5'b11110));
        idleFrames(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleFrames(INV + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("p1 hit after immunity", 16'(bus.player1_HP), 16'(5'b11100));

        // Drive P2 to death, then OVER and the timed return to IDLE.
        for (int k = 0; k < MAX_HP - 1; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            idleFrames(INV + 1);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("p2 dead bars", {11'b0, bus.player2_HP, bus.p2_dead}, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("over winner p1", {13'b0, bus.game_over, bus.winner}, 16'h0005);
        idleFrames(OVF + 1);
        checkOutput("back to idle", act_vec, 16'h0000);

        // Simultaneous last hits give a draw; restart straight from OVER.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < MAX_HP - 1; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            idleFrames(INV + 1);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("draw winner", {11'b0, bus.p1_dead, bus.p2_dead, bus.game_over, bus.winner}, 16'h001F);
        idleFrames(3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("restart from over", act_vec, {5'b11111, 5'b11111, 6'b001000});

        // Heal saturation, then hit beats heal.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("heal at full", 16'(bus.player1_HP), 16'(5'b11111));
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idleFrames(INV + 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("hit beats heal", 16'(bus.player1_HP), 16'(5'b11100));

        // Reset in the middle of immunity, then a clean round.
        idleFrames(5);
        doReset("mid-round reset zeros");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clean restart", act_vec, {5'b11111, 5'b11111, 6'b001000});
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("no residual immunity", 16'(bus.player1_HP), 16'(5'b11110));

        // Random play.
        for (int k = 0; k < 4000; k++) begin
            applyStimulus(($urandom % 300) == 0, ($urandom % 12) == 0, ($urandom % 12) == 0,
                          ($urandom % 30) == 0, ($urandom % 30) == 0);
        end

        @(negedge Clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hp_manager.md
Name: hp_manager

Overview:
- Owns both players' hit-point state and sequences what the HP bar displays.
- Takes one-cycle hit/heal pulses from collision logic and game_start from the menu logic.
- Runs per-player invulnerability and blink timing off the VGA vertical sync.
- Drives the 5-bit thermometer HP vectors into the HP bar renderer, plus death, game-over and winner flags to the game FSM.

Parameters:
- MAX_HP, 5, starting/maximum HP; legal range 1..5; output width fixed at 5.
- INVULN_FRAMES, 60, frames of hit immunity after a non-fatal hit.
- BLINK_HALF, 4, frames per blink half-period while invulnerable.
- OVER_FRAMES, 180, frames held in OVER before auto-return to IDLE.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- VGA_VS  in  1  VGA vertical sync, active-low pulse, synchronous to Clk.
- game_start  in  1  one-cycle pulse to start or restart a round.
- p1_hit, p2_hit  in  1 each  one-cycle damage pulse, 1 HP.
- p1_heal, p2_heal  in  1 each  one-cycle heal pulse, +1 HP.
- player1_HP, player2_HP  out  5 each  thermometer to HP bar; bit4 is the first (leftmost) bar.
- p1_dead, p2_dead  out  1 each  player at 0 HP.
- playing  out  1  round in progress.
- game_over  out  1  high throughout OVER.
- winner  out  2  01=P1, 10=P2, 11=draw, 00=none.

Behaviour:
- All outputs are registered. On reset, asserted at any time including mid-round:
  - top state IDLE; HP counts 0; both HP outputs 5'b00000.
  - dead flags 0, playing 0, game_over 0, winner 00; all counters 0.
- frame_tick:
  - VGA_VS is registered once.
  - frame_tick = previous & ~current, i.e. the falling edge. One Clk pulse per frame.
  - All frame counters advance only on frame_tick.
- Top FSM:
  - IDLE -> PLAY on game_start. Load both counts = MAX_HP, players ALIVE, winner 00.
  - PLAY -> OVER in the cycle after any player enters DEAD.
    - winner = survivor's code; 11 if both died in the same cycle.
    - Load over counter = OVER_FRAMES.
  - OVER -> IDLE when the over counter reaches 0.
  - OVER -> PLAY immediately on game_start (same loads as from IDLE).
  - game_start in PLAY is ignored.
- Per-player FSM (active only in PLAY; HP count is 3 bits):
  - ALIVE, on hit:
    - count -= 1.
    - Count becomes 0 -> DEAD.
    - Otherwise -> INVULN; load inv counter = INVULN_FRAMES and blink counter = 0.
  - INVULN:
    - Hits are ignored.
    - Inv counter decrements per frame_tick; at 0 -> ALIVE.
  - DEAD:
    - Absorbing until the round restarts; hit and heal ignored.
  - Heal (ALIVE or INVULN):
    - count += 1, saturating at MAX_HP; no wrap.
    - Does not change the FSM state.
  - Hit and heal in the same cycle: hit wins, heal dropped. In INVULN both are dropped.
  - Hit/heal pulses outside PLAY are ignored.
- Latency: a hit at edge t is visible on the HP output and dead flag at edge t+1.
- Thermometer encoding:
  - Count n sets bits [4:5-n]. Examples: 5 -> 11111, 3 -> 11100, 0 -> 00000.
  - In INVULN the blink counter wraps at 2*BLINK_HALF.
  - During the second half of that period, the lowest set bit is cleared on the output (last remaining bar flashes).
  - In ALIVE and DEAD the output equals the encoding.
- Outputs per state:
  - OVER: HP outputs freeze at their last PLAY values; game_over = 1.
  - IDLE: HP outputs all 0.
  - playing = 1 only in PLAY.
  - p1_dead / p2_dead hold through OVER; they clear on entering PLAY or IDLE.

Test Plan:
- Reset_n low, then high, then game_start -> next edge player1_HP = player2_HP = 11111, playing = 1.
- p1_hit once -> next edge player1_HP = 11110. Second p1_hit 10 frames later -> ignored. Blink toggles to 11100 on frames 4-7 of each 8-frame period. After 60 frames, steady 11110 and accepts hits.
- Drive P2 down to 1 HP, then hit -> p2_dead = 1, player2_HP = 00000. Next edge: game_over = 1, winner = 01. After 180 frames, IDLE with outputs 0.
- Both players at 1 HP, p1_hit and p2_hit in the same cycle -> both dead, winner = 11.
- p1_heal at 5 HP -> stays 11111. p1_hit and p1_heal in the same cycle at 4 HP, ALIVE -> 3 HP, 11100.
- Reset_n pulsed low mid-round during INVULN -> all outputs zero asynchronously. game_start afterwards -> clean 11111 with no residual invulnerability.
